// File: rtl/ym_slot_seq.sv
// Two-phase c1/c2 enable generator, slot counter and debug-read capture scheduler.
// Optional freeze input enabled by defining YM_SLOT_SEQ_STALL_EN.
module ym_slot_seq #(
  parameter int HALF    = 3,
  parameter int PW      = 1,
  parameter int SLOTS   = 24,
  parameter int DBG_LEN = 8
) (
  input  logic       MCLK,
  input  logic       rst,
  input  logic       en,
  input  logic       stall,
  input  logic       dbg_req,
  output logic       c1,
  output logic       c2,
  output logic [4:0] slot,
  output logic       slot_last,
  output logic       dbg_load,
  output logic       dbg_busy,
  output logic       dbg_done
);

  localparam int PER = 2 * HALF;
  localparam int PHW = $clog2(PER);
  localparam logic [PHW-1:0] PH_LAST   = PHW'(PER - 1);
  localparam logic [4:0]     SLOT_LAST = 5'(SLOTS - 1);
  localparam logic [7:0]     CNT_LAST  = 8'(DBG_LEN - 1);

  typedef enum logic [1:0] {DBG_IDLE, DBG_ARM, DBG_SHIFT, DBG_DONE} dbg_t;

  logic           run;
  logic [PHW-1:0] ph_cnt;
  dbg_t           dbg_state, dbg_nxt;
  logic [7:0]     dbg_cnt, cnt_nxt;
  logic           frz, adv, bnd;

`ifdef YM_SLOT_SEQ_STALL_EN
  assign frz = stall & run;
`else
  assign frz = stall & 1'b0;
`endif

  assign adv = run & ~frz;
  assign bnd = adv & (ph_cnt == PH_LAST);

  // Phase enables decode straight from registers so c1/c2 can never overlap
  assign c1        = adv & (ph_cnt < PHW'(PW));
  assign c2        = adv & (ph_cnt >= PHW'(HALF)) & (ph_cnt < PHW'(HALF + PW));
  assign slot_last = run & (slot == SLOT_LAST);
  assign dbg_load  = (dbg_state == DBG_SHIFT) & (dbg_cnt == 8'd0) & c1;
  assign dbg_busy  = (dbg_state == DBG_ARM) | (dbg_state == DBG_SHIFT);
  assign dbg_done  = (dbg_state == DBG_DONE);

  always_ff @(posedge MCLK) begin
    if (!rst) begin
      run       <= 1'b0;
      ph_cnt    <= '0;
      slot      <= '0;
      dbg_state <= DBG_IDLE;
      dbg_cnt   <= '0;
    end else begin
      if (!run) begin
        run    <= en;
        ph_cnt <= '0;
      end else if (!frz) begin
        ph_cnt <= bnd ? '0 : ph_cnt + 1'b1;
        if (bnd) begin
          run  <= en;
          slot <= (slot == SLOT_LAST) ? 5'd0 : slot + 5'd1;
        end
      end
      dbg_state <= dbg_nxt;
      dbg_cnt   <= cnt_nxt;
    end
  end

  // Capture arms anywhere, but only starts shifting as slot 0 begins
  always_comb begin
    dbg_nxt = dbg_state;
    cnt_nxt = dbg_cnt;
    if (!frz) begin
      case (dbg_state)
        DBG_IDLE:  if (dbg_req & run) dbg_nxt = DBG_ARM;
        DBG_ARM: begin
          if (!run) dbg_nxt = DBG_IDLE;
          else if (bnd & (slot == SLOT_LAST)) begin
            dbg_nxt = DBG_SHIFT;
            cnt_nxt = 8'd0;
          end
        end
        DBG_SHIFT: begin
          if (!run) dbg_nxt = DBG_IDLE;
          else if (bnd) begin
            cnt_nxt = dbg_cnt + 8'd1;
            if (dbg_cnt == CNT_LAST) dbg_nxt = DBG_DONE;
          end
        end
        DBG_DONE:  if (!dbg_req) dbg_nxt = DBG_IDLE;
        default:   dbg_nxt = DBG_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ym_slot_seq.sv
// Bench for ym_slot_seq: directed scenarios plus random traffic against a running-cycle-count model.
module tb_ym_slot_seq;
  localparam int HALF = 3, PW = 1, SLOTS = 24, DBG_LEN = 8, P = 2 * HALF;
`ifdef YM_SLOT_SEQ_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic MCLK = 1'b0, rst = 1'b0, en = 1'b0, stall = 1'b0, dbg_req = 1'b0;
  logic c1, c2, slot_last, dbg_load, dbg_busy, dbg_done;
  logic [4:0] slot;
  int n_chk = 0, n_err = 0;

  ym_slot_seq #(.HALF(HALF), .PW(PW), .SLOTS(SLOTS), .DBG_LEN(DBG_LEN)) dut (
    .MCLK(MCLK), .rst(rst), .en(en), .stall(stall), .dbg_req(dbg_req),
    .c1(c1), .c2(c2), .slot(slot), .slot_last(slot_last),
    .dbg_load(dbg_load), .dbg_busy(dbg_busy), .dbg_done(dbg_done)
  );

  always #5 MCLK = ~MCLK;

  // Model: m_tick counts unfrozen running cycles; phase and slot fall out of it arithmetically.
  // m_dst: 0 idle, 1 armed, 2 shifting (started at tick m_ss), 3 done.
  bit m_run = 1'b0, n_run;
  int m_tick = 0, n_tick, m_dst = 0, n_dst, m_ss = 0, n_ss;
  logic m_frz, m_bnd;
  always_comb begin
    m_frz  = STALL_ON && stall && m_run;
    m_bnd  = m_run && (m_tick % P == P - 1);
    n_run  = m_run; n_tick = m_tick; n_dst = m_dst; n_ss = m_ss;
    if (!rst) begin
      n_run = 1'b0; n_tick = 0; n_dst = 0; n_ss = 0;
    end else if (!m_frz) begin
      case (m_dst)
        0: if (dbg_req && m_run) n_dst = 1;
        1: if (!m_run) n_dst = 0;
           else if (m_bnd && ((m_tick + 1) % (P * SLOTS) == 0)) begin n_dst = 2; n_ss = m_tick + 1; end
        2: if (!m_run) n_dst = 0;
           else if (m_tick + 1 == m_ss + P * DBG_LEN) n_dst = 3;
        default: if (!dbg_req) n_dst = 0;
      endcase
      if (m_run) n_tick = m_tick + 1;
      if (!m_run || m_bnd) n_run = en;
    end
  end
  always @(posedge MCLK) begin
    m_run <= n_run; m_tick <= n_tick; m_dst <= n_dst; m_ss <= n_ss;
  end

  int pos, sl;
  logic live, e1, e2;
  logic [10:0] exp_o;
  wire  [10:0] act_o = {c1, c2, slot, slot_last, dbg_load, dbg_busy, dbg_done};
  always_comb begin
    pos  = m_tick % P;
    sl   = (m_tick / P) % SLOTS;
    live = m_run && !m_frz;
    e1   = live && pos < PW;
    e2   = live && pos >= HALF && pos < HALF + PW;
    exp_o = {e1, e2, 5'(sl), m_run && sl == SLOTS - 1,
             m_dst == 2 && m_tick == m_ss && e1, m_dst == 1 || m_dst == 2, m_dst == 3};
  end

  task automatic step();
    @(posedge MCLK); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; stall = 1'b0; dbg_req = 1'b0;
    repeat (4) begin
      step();
      n_chk++; if (act_o !== 11'd0) begin n_err++; $display("FAIL reset got=%h exp=0", act_o); end
    end
  endtask

  task automatic test_startup();
    rst = 1'b1; en = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      step();
      n_chk++; if (act_o !== exp_o) begin n_err++; $display("FAIL startup_model k=%0d got=%h exp=%h", k, act_o, exp_o); end
      if (k == 1 || k == 7 || k == 13) begin
        n_chk++; if (c1 !== 1'b1) begin n_err++; $display("FAIL startup_c1 k=%0d got=%b exp=1", k, c1); end
      end
      if (k == 4 || k == 10) begin
        n_chk++; if (c2 !== 1'b1) begin n_err++; $display("FAIL startup_c2 k=%0d got=%b exp=1", k, c2); end
      end
      if (k == 144) begin
        n_chk++; if ({slot, slot_last} !== {5'd23, 1'b1}) begin n_err++; $display("FAIL startup_last got=%0d/%b exp=23/1", slot, slot_last); end
      end
      if (k == 145) begin
        n_chk++; if ({slot, slot_last} !== {5'd0, 1'b0}) begin n_err++; $display("FAIL startup_wrap got=%0d/%b exp=0/0", slot, slot_last); end
      end
    end
  endtask

  task automatic test_stop();
    int w;
    logic [4:0] hold;
    hold = 5'd0;
    repeat ($urandom_range(10, 40)) begin
      step();
      n_chk++; if (act_o !== exp_o) begin n_err++; $display("FAIL stop_pre got=%h exp=%h", act_o, exp_o); end
    end
    w = 0;
    while (m_tick % P != 1 && w < P) begin step(); w++; end
    en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_chk++; if (act_o !== exp_o) begin n_err++; $display("FAIL stop_model k=%0d got=%h exp=%h", k, act_o, exp_o); end
      if (k == 2) begin
        n_chk++; if (c2 !== 1'b1) begin n_err++; $display("FAIL stop_c2_due got=%b exp=1", c2); end
      end
      if (k == 4) hold = (slot == 5'd23) ? 5'd0 : slot + 5'd1;
      if (k >= 5) begin
        n_chk++; if ({c1, c2, slot} !== {2'b00, hold}) begin n_err++; $display("FAIL stop_hold k=%0d got=%b%b/%0d exp=00/%0d", k, c1, c2, slot, hold); end
      end
    end
    en = 1'b1;
    step();
    n_chk++; if (c1 !== 1'b1) begin n_err++; $display("FAIL stop_restart_c1 got=%b exp=1", c1); end
  endtask

  task automatic test_debug();
    int w, kload, kdone, nload;
    w = 0;
    while ((m_tick / P) % SLOTS != 5 && w < 200) begin step(); w++; end
    n_chk++; if (w >= 200) begin n_err++; $display("FAIL dbg_wait_slot5 got=timeout exp=slot5"); end
    dbg_req = 1'b1;
    step();
    n_chk++; if (dbg_busy !== 1'b1) begin n_err++; $display("FAIL dbg_busy got=%b exp=1", dbg_busy); end
    kload = -1000; kdone = -1; nload = 0;
    for (int k = 0; k < 400 && kdone < 0; k++) begin
      step();
      n_chk++; if (act_o !== exp_o) begin n_err++; $display("FAIL dbg_model k=%0d got=%h exp=%h", k, act_o, exp_o); end
      if (dbg_load === 1'b1) begin
        nload++; kload = k;
        n_chk++; if ({c1, slot} !== {1'b1, 5'd0}) begin n_err++; $display("FAIL dbg_load_pos got=%b/%0d exp=1/0", c1, slot); end
      end
      if (dbg_done === 1'b1) kdone = k;
    end
    n_chk++; if (nload != 1) begin n_err++; $display("FAIL dbg_load_count got=%0d exp=1", nload); end
    n_chk++; if (kdone - kload != P * DBG_LEN) begin n_err++; $display("FAIL dbg_done_latency got=%0d exp=%0d", kdone - kload, P * DBG_LEN); end
    repeat (3) begin
      step();
      n_chk++; if (dbg_done !== 1'b1) begin n_err++; $display("FAIL dbg_done_hold got=%b exp=1", dbg_done); end
    end
    dbg_req = 1'b0;
    step();
    n_chk++; if (dbg_done !== 1'b0) begin n_err++; $display("FAIL dbg_done_clear got=%b exp=0", dbg_done); end
  endtask

  task automatic test_reset_mid();
    int w;
    dbg_req = 1'b1; w = 0;
    while (!(m_dst == 2 && (m_tick - m_ss) / P == 3) && w < 400) begin step(); w++; end
    n_chk++; if (w >= 400) begin n_err++; $display("FAIL rstmid_wait got=timeout exp=shift_cnt3"); end
    rst = 1'b0;
    step();
    n_chk++; if (act_o !== 11'd0) begin n_err++; $display("FAIL rstmid_zero got=%h exp=0", act_o); end
    rst = 1'b1; dbg_req = 1'b0;
    for (int k = 0; k < 120; k++) begin
      step();
      n_chk++; if (act_o !== exp_o || dbg_done !== 1'b0) begin n_err++; $display("FAIL rstmid_after k=%0d got=%h exp=%h", k, act_o, exp_o); end
    end
  endtask

  task automatic test_stall();
    int k;
    logic [4:0] s0;
    rst = 1'b0; step(); step();
    rst = 1'b1; en = 1'b1; k = 0;
    repeat (3) begin step(); k++; end
    s0 = slot;
    stall = 1'b1;
    repeat (10) begin
      step(); k++;
      n_chk++; if (act_o !== exp_o) begin n_err++; $display("FAIL stall_model k=%0d got=%h exp=%h", k, act_o, exp_o); end
`ifdef YM_SLOT_SEQ_STALL_EN
      n_chk++; if ({c1, c2, slot} !== {2'b00, s0}) begin n_err++; $display("FAIL stall_frozen got=%b%b/%0d exp=00/%0d", c1, c2, slot, s0); end
`endif
    end
    stall = 1'b0;
    repeat (20) begin
      step(); k++;
      n_chk++; if (act_o !== exp_o) begin n_err++; $display("FAIL stall_resume_model k=%0d got=%h exp=%h", k, act_o, exp_o); end
`ifdef YM_SLOT_SEQ_STALL_EN
      if (k == 14) begin
        n_chk++; if (c2 !== 1'b1) begin n_err++; $display("FAIL stall_resume_c2 got=%b exp=1", c2); end
      end
`else
      n_chk++;
      if ({c1, c2, slot} !== {((k - 1) % P == 0), ((k - 1) % P == HALF), 5'((k - 1) / P)}) begin
        n_err++; $display("FAIL stall_ignored k=%0d got=%b%b/%0d", k, c1, c2, slot);
      end
`endif
    end
  endtask

  task automatic test_abort();
    dbg_req = 1'b1;
    step();
    n_chk++; if (dbg_busy !== 1'b1) begin n_err++; $display("FAIL abort_arm got=%b exp=1", dbg_busy); end
    en = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      n_chk++; if (act_o !== exp_o || dbg_done !== 1'b0) begin n_err++; $display("FAIL abort_model k=%0d got=%h exp=%h", k, act_o, exp_o); end
      if (k == P + 1) begin
        n_chk++; if (dbg_busy !== 1'b0) begin n_err++; $display("FAIL abort_idle got=%b exp=0", dbg_busy); end
      end
    end
    dbg_req = 1'b0; en = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) dbg_req = ~dbg_req;
      step();
      n_chk++; if (act_o !== exp_o) begin n_err++; $display("FAIL random k=%0d got=%h exp=%h", k, act_o, exp_o); end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stop();
    test_debug();
    test_reset_mid();
    test_stall();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
